// File: rtl/mac_result_clip_pack_if.sv
// Handshake bundle between the MAC result stage and the packed SRAM write port.
// The master side drives control and samples; the slave side is the clip/pack block.
interface mac_result_clip_pack_if #(
   parameter int ADDR_W = 18
);
   logic              start;
   logic [ADDR_W-1:0] base_address;
   logic [ADDR_W-1:0] word_count;
   logic              in_valid;
   logic [63:0]       in_result;
   logic              in_ready;
   logic              out_valid;
   logic [15:0]       out_data;
   logic [ADDR_W-1:0] out_address;
   logic              out_ready;
   logic              busy;
   logic              done;

   modport master (
      output start, base_address, word_count, in_valid, in_result, out_ready,
      input  in_ready, out_valid, out_data, out_address, busy, done
   );

   modport slave (
      input  start, base_address, word_count, in_valid, in_result, out_ready,
      output in_ready, out_valid, out_data, out_address, busy, done
   );
endinterface

// File: rtl/mac_result_clip_pack.sv
// Rounds, shifts and clips 64-bit MAC results to 8-bit pixels, packs two per
// 16-bit word and writes a programmed run of words through a small FIFO.
module mac_result_clip_pack #(
   parameter int SHIFT      = 16,
   parameter int ROUND      = 1,
   parameter int FIFO_DEPTH = 2,
   parameter int ADDR_W     = 18
) (
   input logic                   Clock_50,
   input logic                   Resetn,
   mac_result_clip_pack_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic signed [64:0] RND_ADD   = (ROUND != 0) ? (65'sd1 <<< (SHIFT - 1)) : 65'sd0;
   localparam logic signed [64:0] MAX_PIX   = 65'sd255;
   localparam logic [PTR_W:0]     FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]     ZERO_CNT  = {(PTR_W + 1){1'b0}};
   localparam logic [PTR_W:0]     ONE_CNT   = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0]   ZERO_PTR  = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]   ONE_PTR   = {{(PTR_W - 1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0]  ZERO_ADDR = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0]  ONE_ADDR  = {{(ADDR_W - 1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]    ZERO_SAMP = {(ADDR_W + 1){1'b0}};
   localparam logic [ADDR_W:0]    ONE_SAMP  = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // 65-bit signed add keeps the rounding constant from overflowing the accumulator range.
   function automatic logic [7:0] clip_pixel(input logic [63:0] acc);
      logic signed [64:0] t;
      logic signed [64:0] s;
      t = $signed({acc[63], acc}) + RND_ADD;
      s = t >>> SHIFT;
      if (s[64]) begin
         clip_pixel = 8'd0;
      end else if (s > MAX_PIX) begin
         clip_pixel = 8'd255;
      end else begin
         clip_pixel = s[7:0];
      end
   endfunction

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_words_left;
   logic [ADDR_W:0]   r_samples_left;
   logic              r_half;
   logic [7:0]        r_hold;
   logic [15:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;

   logic              w_full;
   logic              w_empty;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic              w_start_run;
   logic [7:0]        w_pix;

   assign w_full      = (r_count == FULL_CNT);
   assign w_empty     = (r_count == ZERO_CNT);
   // A held even pixel with no FIFO room would have nowhere to go on the next accept.
   assign w_in_ready  = (r_state == S_RUN) && !(r_half && w_full);
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_push      = w_accept && r_half;
   assign w_pop       = !w_empty && bus.out_ready;
   assign w_start_run = (r_state == S_IDLE) && bus.start && (bus.word_count != ZERO_ADDR);
   assign w_pix       = clip_pixel(bus.in_result);

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = !w_empty;
   assign bus.out_data    = r_mem[r_rd_ptr];
   assign bus.out_address = r_addr;
   assign bus.busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign bus.done        = (r_state == S_DONE);

   // Control FSM state register.
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; the final pop is seen in DRAIN because the last word is pushed on the RUN exit edge.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.word_count == ZERO_ADDR) begin
                  w_next = S_DONE;
               end else begin
                  w_next = S_RUN;
               end
            end else begin
               w_next = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_accept && (r_samples_left == ONE_SAMP)) begin
               w_next = S_DRAIN;
            end else begin
               w_next = S_RUN;
            end
         end
         S_DRAIN: begin
            if ((w_pop && (r_words_left == ONE_ADDR)) || (r_words_left == ZERO_ADDR)) begin
               w_next = S_DONE;
            end else begin
               w_next = S_DRAIN;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Run counters, address and pixel pairing.
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         r_addr         <= ZERO_ADDR;
         r_words_left   <= ZERO_ADDR;
         r_samples_left <= ZERO_SAMP;
         r_half         <= 1'b0;
         r_hold         <= 8'd0;
      end else if (w_start_run) begin
         r_addr         <= bus.base_address;
         r_words_left   <= bus.word_count;
         r_samples_left <= {bus.word_count, 1'b0};
         r_half         <= 1'b0;
      end else begin
         if (w_pop) begin
            r_addr       <= r_addr + ONE_ADDR;
            r_words_left <= r_words_left - ONE_ADDR;
         end
         if (w_accept) begin
            r_samples_left <= r_samples_left - ONE_SAMP;
            r_half         <= !r_half;
            if (!r_half) begin
               r_hold <= w_pix;
            end
         end
      end
   end

   // Packed-word FIFO storage and occupancy.
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= 16'h0000;
         end
         r_wr_ptr <= ZERO_PTR;
         r_rd_ptr <= ZERO_PTR;
         r_count  <= ZERO_CNT;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {r_hold, w_pix};
            r_wr_ptr        <= r_wr_ptr + ONE_PTR;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ONE_PTR;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + ONE_CNT;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - ONE_CNT;
         end
      end
   end
endmodule

// File: tb/tb_mac_result_clip_pack.sv
// Randomised self-checking bench for mac_result_clip_pack against a floor-division
// pixel model; a second instance with ROUND=0 covers truncation.
module tb_mac_result_clip_pack;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   mac_result_clip_pack_if #(.ADDR_W(18)) bus ();
   mac_result_clip_pack_if #(.ADDR_W(18)) bus_t ();

   mac_result_clip_pack #(.SHIFT(16), .ROUND(1), .FIFO_DEPTH(2), .ADDR_W(18)) u_dut (
      .Clock_50 (clk),
      .Resetn   (rst_n),
      .bus      (bus)
   );

   mac_result_clip_pack #(.SHIFT(16), .ROUND(0), .FIFO_DEPTH(2), .ADDR_W(18)) u_dut_trunc (
      .Clock_50 (clk),
      .Resetn   (rst_n),
      .bus      (bus_t)
   );

   always #5 clk = ~clk;

   logic [63:0] stim[$];
   logic [15:0] cap_data[$];
   logic [17:0] cap_addr[$];
   int acc_cnt, done_cyc, last_pop_cyc, stall_err, busy_err, extra_rdy;
   int valid_seen, acc_at_stall, done_pulses, timeout;
   logic rdy_at_stall;

   // Pixel = clip(floor((r + rnd) / 65536)), evaluated with wide signed division.
   function automatic logic [7:0] ref_pix(input logic [63:0] r, input int rnd);
      logic signed [71:0] v;
      logic signed [71:0] q;
      v = $signed({{8{r[63]}}, r});
      if (rnd != 0) v = v + 72'sd32768;
      q = v / 72'sd65536;
      if (v < 72'sd0 && q * 72'sd65536 != v) q = q - 72'sd1;
      if (q < 72'sd0) return 8'd0;
      if (q > 72'sd255) return 8'd255;
      return q[7:0];
   endfunction

   function automatic logic [63:0] rand_sample();
      int k;
      logic [63:0] v;
      k = $urandom_range(3);
      case (k)
         0: v = {40'd0, 8'($urandom_range(255)), 16'($urandom)};
         1: v = {$urandom, $urandom};
         2: v = 64'd0 - {32'd0, 16'($urandom_range(600)), 16'($urandom)};
         default: v = {40'd0, 8'($urandom), 16'h7FFF + 16'($urandom_range(1))};
      endcase
      return v;
   endfunction

   function automatic logic [15:0] exp_word(input int i);
      return {ref_pix(stim[2*i], 1), ref_pix(stim[2*i+1], 1)};
   endfunction

   task automatic do_run(input logic [17:0] base, input logic [17:0] wc, input int valid_pct,
                         input int ready_pct, input int stall, input int restart_cyc, input int budget);
      int idx;
      logic held;
      logic [15:0] hd;
      logic [17:0] ha;
      cap_data.delete();
      cap_addr.delete();
      acc_cnt = 0; done_cyc = -1; last_pop_cyc = -1; stall_err = 0; busy_err = 0; extra_rdy = 0;
      valid_seen = 0; acc_at_stall = -1; done_pulses = 0; timeout = 0; rdy_at_stall = 1'bx;
      idx = 0; held = 1'b0; hd = 16'h0000; ha = 18'h0;
      bus.base_address = base;
      bus.word_count   = wc;
      bus.start        = 1'b1;
      bus.in_valid     = 1'b0;
      bus.out_ready    = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         if (held && (bus.out_valid !== 1'b1 || bus.out_data !== hd || bus.out_address !== ha)) stall_err++;
         if (bus.out_valid === 1'b1) valid_seen++;
         if (bus.done === 1'b1) begin
            done_pulses++;
            if (done_cyc < 0) done_cyc = cyc;
            if (bus.busy !== 1'b0) busy_err++;
         end else if (done_cyc < 0 && bus.busy !== 1'b1) begin
            busy_err++;
         end
         if (cyc == stall + 1) begin
            acc_at_stall = acc_cnt;
            rdy_at_stall = bus.in_ready;
         end
         if (done_cyc > 0 && cyc >= done_cyc + 2) break;
         bus.start = (cyc == restart_cyc);
         if (cyc == restart_cyc) begin
            bus.base_address = base ^ 18'h00155;
            bus.word_count   = 18'd7;
         end
         bus.in_valid  = (idx < stim.size()) && ($urandom_range(99) < valid_pct);
         bus.in_result = (idx < stim.size()) ? stim[idx] : {$urandom, $urandom};
         bus.out_ready = (cyc > stall) && ($urandom_range(99) < ready_pct);
         #1;
         if (bus.in_valid && bus.in_ready === 1'b1) begin
            idx++;
            acc_cnt++;
         end else if (idx >= stim.size() && bus.in_ready === 1'b1) begin
            extra_rdy++;
         end
         held = (bus.out_valid === 1'b1) && !bus.out_ready;
         hd = bus.out_data;
         ha = bus.out_address;
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            cap_data.push_back(bus.out_data);
            cap_addr.push_back(bus.out_address);
            last_pop_cyc = cyc;
         end
         @(negedge clk);
      end
      if (done_cyc < 0) timeout = 1;
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_data !== 16'h0000 || bus.out_address !== 18'h0) begin errors++; $display("FAIL reset_data_addr: got %h/%h want 0/0", bus.out_data, bus.out_address); end
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b/%b want 0/0", bus.busy, bus.done); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_arith();
      stim.delete();
      stim.push_back(64'h0000_0000_0080_0000);
      stim.push_back(64'h0000_0000_0000_7FFF);
      do_run(18'h00123, 18'd1, 100, 100, 0, -1, 50);
      checks++; if (cap_data.size() != 1) begin errors++; $display("FAIL arith_count: got %0d want 1", cap_data.size()); end
      else begin
         checks++; if (cap_data[0] !== 16'h8000) begin errors++; $display("FAIL arith_data: got %h want 8000", cap_data[0]); end
         checks++; if (cap_addr[0] !== 18'h00123) begin errors++; $display("FAIL arith_addr: got %h want 00123", cap_addr[0]); end
      end
      checks++; if (timeout != 0 || done_cyc != last_pop_cyc + 1) begin errors++; $display("FAIL arith_done_timing: got done %0d pop %0d want done=pop+1", done_cyc, last_pop_cyc); end
      checks++; if (busy_err != 0) begin errors++; $display("FAIL arith_busy: got %0d bad cycles want 0", busy_err); end
      stim.delete();
      stim.push_back(64'd0 - (64'd5 << 16));
      stim.push_back(64'd300 << 16);
      do_run(18'h00040, 18'd1, 100, 100, 0, -1, 50);
      checks++; if (cap_data.size() != 1 || cap_data[0] !== 16'h00FF || cap_data[0] !== exp_word(0)) begin
         errors++; $display("FAIL clip_data: got %h (n=%0d) want 00ff", (cap_data.size() > 0) ? cap_data[0] : 16'hxxxx, cap_data.size()); end
   endtask

   task automatic test_rounding();
      logic [15:0] exp_r;
      logic [15:0] exp_t;
      exp_r = {ref_pix(64'h8000, 1), ref_pix(64'h8000, 1)};
      exp_t = {ref_pix(64'h8000, 0), ref_pix(64'h8000, 0)};
      bus.start = 1'b1; bus.base_address = 18'h10; bus.word_count = 18'd1; bus.out_ready = 1'b0;
      bus_t.start = 1'b1; bus_t.base_address = 18'h10; bus_t.word_count = 18'd1; bus_t.out_ready = 1'b0;
      @(negedge clk);
      bus.start = 1'b0; bus_t.start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.in_valid = 1'b1; bus.in_result = 64'h8000;
         bus_t.in_valid = 1'b1; bus_t.in_result = 64'h8000;
         @(negedge clk);
      end
      bus.in_valid = 1'b0; bus_t.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_r || exp_r !== 16'h0101) begin errors++; $display("FAIL round_up: got %b/%h want 1/%h", bus.out_valid, bus.out_data, exp_r); end
      checks++; if (bus_t.out_valid !== 1'b1 || bus_t.out_data !== exp_t || exp_t !== 16'h0000) begin errors++; $display("FAIL round_trunc: got %b/%h want 1/%h", bus_t.out_valid, bus_t.out_data, exp_t); end
      bus.out_ready = 1'b1; bus_t.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0; bus_t.out_ready = 1'b0;
      checks++; if (bus.done !== 1'b1 || bus_t.done !== 1'b1) begin errors++; $display("FAIL round_done: got %b/%b want 1/1", bus.done, bus_t.done); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      stim.delete();
      for (int i = 0; i < 6; i++) stim.push_back(rand_sample());
      do_run(18'h00300, 18'd3, 100, 100, 12, -1, 100);
      checks++; if (acc_at_stall != 5 || rdy_at_stall !== 1'b0) begin errors++; $display("FAIL bp_accepts: got %0d accepts ready=%b want 5 ready=0", acc_at_stall, rdy_at_stall); end
      checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_err); end
      checks++; if (cap_data.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", cap_data.size()); end
      for (int i = 0; i < cap_data.size() && i < 3; i++) begin
         checks++; if (cap_data[i] !== exp_word(i) || cap_addr[i] !== 18'h00300 + 18'(i)) begin
            errors++; $display("FAIL bp_word%0d: got %h@%h want %h@%h", i, cap_data[i], cap_addr[i], exp_word(i), 18'h00300 + 18'(i)); end
      end
   endtask

   task automatic test_wrap();
      stim.delete();
      for (int i = 0; i < 8; i++) stim.push_back(rand_sample());
      do_run(18'h3FFFE, 18'd4, 100, 100, 0, -1, 100);
      checks++; if (cap_addr.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", cap_addr.size()); end
      for (int i = 0; i < cap_addr.size() && i < 4; i++) begin
         checks++; if (cap_addr[i] !== 18'h3FFFE + 18'(i) || cap_data[i] !== exp_word(i)) begin
            errors++; $display("FAIL wrap_word%0d: got %h@%h want %h@%h", i, cap_data[i], cap_addr[i], exp_word(i), 18'h3FFFE + 18'(i)); end
      end
      checks++; if (extra_rdy != 0) begin errors++; $display("FAIL wrap_ready_after_last: got %0d cycles want 0", extra_rdy); end
      checks++; if (busy_err != 0 || timeout != 0) begin errors++; $display("FAIL wrap_busy_done: got busy_err %0d timeout %0d want 0/0", busy_err, timeout); end
   endtask

   task automatic test_edge_controls();
      stim.delete();
      do_run(18'h00077, 18'd0, 100, 100, 0, -1, 20);
      checks++; if (done_cyc != 1 || valid_seen != 0 || done_pulses != 1) begin
         errors++; $display("FAIL zero_count: got done@%0d valid %0d pulses %0d want 1/0/1", done_cyc, valid_seen, done_pulses); end
      stim.delete();
      for (int i = 0; i < 6; i++) stim.push_back(rand_sample());
      do_run(18'h00200, 18'd3, 50, 60, 0, 3, 300);
      checks++; if (cap_addr.size() != 3 || done_pulses != 1) begin errors++; $display("FAIL restart_count: got %0d words %0d pulses want 3/1", cap_addr.size(), done_pulses); end
      for (int i = 0; i < cap_addr.size() && i < 3; i++) begin
         checks++; if (cap_addr[i] !== 18'h00200 + 18'(i) || cap_data[i] !== exp_word(i)) begin
            errors++; $display("FAIL restart_word%0d: got %h@%h want %h@%h", i, cap_data[i], cap_addr[i], exp_word(i), 18'h00200 + 18'(i)); end
      end
   endtask

   task automatic test_reset_mid_run();
      bus.start = 1'b1; bus.base_address = 18'h01000; bus.word_count = 18'd4; bus.out_ready = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1; bus.in_result = rand_sample();
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: got valid %b busy %b want 1/1", bus.out_valid, bus.busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
         errors++; $display("FAIL midrst_abort: got valid %b busy %b ready %b done %b want 0/0/0/0", bus.out_valid, bus.busy, bus.in_ready, bus.done); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrst_post: got valid %b done %b want 0/0", bus.out_valid, bus.done); end
      stim.delete();
      for (int i = 0; i < 8; i++) stim.push_back(rand_sample());
      do_run(18'h02000, 18'd4, 80, 80, 0, -1, 300);
      checks++; if (cap_data.size() != 4 || done_pulses != 1) begin errors++; $display("FAIL midrst_fresh_count: got %0d words %0d pulses want 4/1", cap_data.size(), done_pulses); end
      for (int i = 0; i < cap_data.size() && i < 4; i++) begin
         checks++; if (cap_data[i] !== exp_word(i) || cap_addr[i] !== 18'h02000 + 18'(i)) begin
            errors++; $display("FAIL midrst_word%0d: got %h@%h want %h@%h", i, cap_data[i], cap_addr[i], exp_word(i), 18'h02000 + 18'(i)); end
      end
   endtask

   task automatic test_random();
      logic [17:0] base;
      logic [17:0] wc;
      for (int r = 0; r < 8; r++) begin
         wc = 18'($urandom_range(6, 1));
         base = 18'($urandom);
         stim.delete();
         for (int i = 0; i < 2 * int'(wc); i++) stim.push_back(rand_sample());
         do_run(base, wc, $urandom_range(100, 40), $urandom_range(100, 30), 0, -1, 400);
         checks++; if (cap_data.size() != int'(wc) || timeout != 0) begin errors++; $display("FAIL rand%0d_count: got %0d timeout %0d want %0d", r, cap_data.size(), timeout, wc); end
         for (int i = 0; i < cap_data.size() && i < int'(wc); i++) begin
            checks++; if (cap_data[i] !== exp_word(i) || cap_addr[i] !== base + 18'(i)) begin
               errors++; $display("FAIL rand%0d_word%0d: got %h@%h want %h@%h", r, i, cap_data[i], cap_addr[i], exp_word(i), base + 18'(i)); end
         end
         checks++; if (done_cyc != last_pop_cyc + 1 || stall_err != 0 || busy_err != 0) begin
            errors++; $display("FAIL rand%0d_ctrl: got done %0d pop %0d stall %0d busy %0d want pop+1/0/0", r, done_cyc, last_pop_cyc, stall_err, busy_err); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0; bus.base_address = 18'h0; bus.word_count = 18'h0;
      bus.in_valid = 1'b0; bus.in_result = 64'h0; bus.out_ready = 1'b0;
      bus_t.start = 1'b0; bus_t.base_address = 18'h0; bus_t.word_count = 18'h0;
      bus_t.in_valid = 1'b0; bus_t.in_result = 64'h0; bus_t.out_ready = 1'b0;
      test_reset();
      test_arith();
      test_rounding();
      test_backpressure();
      test_wrap();
      test_edge_controls();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mac_result_clip_pack.md
Name: mac_result_clip_pack

Overview:
- Downstream consumer of the multiply-accumulate unit's 64-bit accumulator in the decompressor datapath.
- For each completed accumulation it rounds, arithmetic-shifts and clips the result to an 8-bit pixel.
- Packs two pixels per 16-bit SRAM word and buffers words in a small FIFO.
- Drives a valid/ready write port with an auto-incrementing address for a programmed run of words.

Parameters:
- SHIFT, 16, right-shift applied to the accumulator (fixed-point fraction bits); legal range 1..32.
- ROUND, 1, 1 = add 2^(SHIFT-1) before shifting; 0 = truncate.
- FIFO_DEPTH, 2, number of packed 16-bit words buffered; power of two, ≥2.
- ADDR_W, 18, SRAM word-address width.

Ports:
- Clock_50  in  1  system clock; all state on rising edge.
- Resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches base_address and word_count and begins a run.
- base_address  in  ADDR_W  first write address of the run.
- word_count  in  ADDR_W  number of 16-bit words in the run.
- in_valid  in  1  in_result holds a finished accumulation.
- in_result  in  64  accumulator value, interpreted as two's-complement signed.
- in_ready  out  1  block accepts in_result this cycle.
- out_valid  out  1  out_data/out_address hold a word to write.
- out_data  out  16  {even pixel [15:8], odd pixel [7:0]}.
- out_address  out  ADDR_W  SRAM address for out_data.
- out_ready  in  1  write port consumes the word this cycle.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the last word of the run is consumed.

Behaviour:
- Reset: all outputs 0; FIFO empty; half flag cleared; FSM to IDLE.
- FSM states:
  - IDLE: accepts start.
  - RUN: accepts input samples.
  - DRAIN: no input accepted; waits for FIFO empty.
  - DONE: drives done=1 for one cycle, then returns to IDLE.
- IDLE + start:
  - word_count=0 goes straight to DONE (done asserted the following cycle).
  - Otherwise go to RUN with addr=base_address, words_left=word_count, samples_left=2*word_count.
- start is ignored outside IDLE.
- Accept rule: an input is accepted when in_valid && in_ready.
  - in_ready = RUN && !(half==1 && fifo_full), where half==1 means an even pixel is held.
  - in_ready is combinational from registered state only; it never depends on in_valid.
- Arithmetic on each accepted sample:
  - t = in_result + (ROUND ? 2^(SHIFT-1) : 0), computed in 65-bit signed so it cannot overflow.
  - s = t >>> SHIFT (arithmetic shift).
  - pix = 0 if s<0, 255 if s>255, else s[7:0].
- Packing:
  - half=0: pix goes to hold[7:0] and half becomes 1.
  - half=1: push {hold, pix} into the FIFO and clear half.
  - The pushed word is visible on out_data one cycle after the accept.
- After samples_left reaches 0, go to DRAIN.
- Output side:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - out_address = current address register.
  - On out_valid && out_ready: pop, increment address (wraps modulo 2^ADDR_W), decrement words_left.
  - out_data/out_address must hold stable while out_valid && !out_ready.
- Simultaneous push and pop with the FIFO full is legal; count stays unchanged.
- DRAIN moves to DONE in the cycle after the final pop (words_left == 0).
- busy = RUN || DRAIN.
- Resetn asserted mid-run aborts immediately: FIFO contents and the half pixel are discarded, no done pulse.

Test Plan:
- Arithmetic:
  - SHIFT=16, ROUND=1, word_count=1; results 0x0000_0000_0080_0000 then 0x0000_0000_0000_7FFF → out_data=0x8000 at base_address; done one cycle after the pop.
  - Clipping: results −5·2^16 then 300·2^16 → out_data=0x00FF.
  - Rounding boundary: 0x0000_8000 rounds to 1 with ROUND=1, and to 0 with ROUND=0.
- Backpressure: out_ready=0, stream 6 samples with in_valid held high → in_ready falls after 5 accepts (FIFO holds 2 words plus half pixel); release out_ready → 3 words written in order with stable data while stalled.
- Run length / wrap: base_address=0x3FFFE, word_count=4, out_ready=1 → addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; in_ready low after the 8th sample; busy drops with done.
- Edge controls:
  - word_count=0 → done pulses with no out_valid.
  - start during RUN → ignored; address sequence unchanged.
- Reset mid-run: assert Resetn low after 3 accepted samples → out_valid=0, busy=0, FIFO empty; a new start produces a fresh, uncorrupted sequence.
